// File: rtl/qpmm_out_ctrl_if.sv
// Issue/result handshake bundle between the QPMM core wrapper and qpmm_out_ctrl.
interface qpmm_out_ctrl_if #(
  parameter int unsigned ZW    = 288,
  parameter int unsigned PW    = 256,
  parameter int unsigned TAG_W = 4
);
  logic             iss_valid;
  logic [TAG_W-1:0] iss_tag;
  logic             iss_ready;
  logic [ZW-1:0]    qpmm_z;
  logic             out_valid;
  logic             out_ready;
  logic [PW-1:0]    out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output iss_valid, iss_tag, qpmm_z, out_ready,
    input  iss_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  iss_valid, iss_tag, qpmm_z, out_ready,
    output iss_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/qpmm_out_ctrl.sv
// Credit-gated issue, latency tracking, mod-P reduction and output FIFO for the QPMM core.
// Optional sticky out-of-range flag (range_err) enabled by QPMM_OUT_RANGE_CHK_EN.
module qpmm_out_ctrl #(
  parameter int unsigned ZW       = 288,
  parameter int unsigned PW       = 256,
  parameter int unsigned PIPE_LAT = 40,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned TAG_W    = 4,
  parameter logic [PW-1:0] P      = 256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47
) (
  input  logic           clk,
  input  logic           rstn,
  qpmm_out_ctrl_if.slave bus
`ifdef QPMM_OUT_RANGE_CHK_EN
  ,
  output logic           range_err
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [ZW-1:0] P1_Z  = ZW'(P);
  localparam logic [ZW-1:0] P2_Z  = P1_Z + P1_Z;
  localparam logic [PW-1:0] P2_LO = P2_Z[PW-1:0];
`ifdef QPMM_OUT_RANGE_CHK_EN
  localparam logic [ZW-1:0] P3_Z  = P2_Z + P1_Z;
`endif

  logic          iss_fire;
  logic          pop;
  logic [CW-1:0] credits;
  logic [CW-1:0] credits_nxt;
  logic          iss_ready_q;
  logic          out_valid_q;

  assign iss_fire      = bus.iss_valid && iss_ready_q;
  assign pop           = out_valid_q && bus.out_ready;
  assign bus.iss_ready = iss_ready_q;
  assign bus.out_valid = out_valid_q;

  // Credits: one per op from issue until its result leaves the FIFO.
  always_comb begin
    credits_nxt = credits;
    if (iss_fire && !pop)      credits_nxt = credits - CW'(1);
    else if (pop && !iss_fire) credits_nxt = credits + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      credits     <= CW'(DEPTH);
      iss_ready_q <= 1'b1;
    end else begin
      credits     <= credits_nxt;
      iss_ready_q <= (credits_nxt != '0);
    end
  end

  logic [PIPE_LAT-1:0]            pipe_v;
  logic [PIPE_LAT-1:0][TAG_W-1:0] pipe_tag;
  logic                           v_z;
  logic [TAG_W-1:0]               tag_z;

  assign v_z   = pipe_v[PIPE_LAT-1];
  assign tag_z = pipe_tag[PIPE_LAT-1];

  always_ff @(posedge clk) begin
    if (rstn) pipe_v <= '0;
    else      pipe_v <= {pipe_v[PIPE_LAT-2:0], iss_fire};
  end

  always_ff @(posedge clk) begin
    pipe_tag <= {pipe_tag[PIPE_LAT-2:0], bus.iss_tag};
  end

  // R1: sign of Z-kP kept as a compare; only the low PW bits of each difference matter.
  logic             r1_v;
  logic [TAG_W-1:0] r1_tag;
  logic [PW-1:0]    r1_z;
  logic [PW-1:0]    r1_d1;
  logic [PW-1:0]    r1_d2;
  logic             r1_ge1;
  logic             r1_ge2;
`ifdef QPMM_OUT_RANGE_CHK_EN
  logic             r1_ge3;
`endif

  always_ff @(posedge clk) begin
    if (rstn) r1_v <= 1'b0;
    else      r1_v <= v_z;
  end

  always_ff @(posedge clk) begin
    if (v_z) begin
      r1_tag <= tag_z;
      r1_z   <= bus.qpmm_z[PW-1:0];
      r1_d1  <= bus.qpmm_z[PW-1:0] - P;
      r1_d2  <= bus.qpmm_z[PW-1:0] - P2_LO;
      r1_ge1 <= (bus.qpmm_z >= P1_Z);
      r1_ge2 <= (bus.qpmm_z >= P2_Z);
`ifdef QPMM_OUT_RANGE_CHK_EN
      r1_ge3 <= (bus.qpmm_z >= P3_Z);
`endif
    end
  end

  logic             r2_v;
  logic [TAG_W-1:0] r2_tag;
  logic [PW-1:0]    r2_data;
  logic [PW-1:0]    red_sel;

  always_comb begin
    red_sel = r1_z;
    if (r1_ge2)      red_sel = r1_d2;
    else if (r1_ge1) red_sel = r1_d1;
  end

  always_ff @(posedge clk) begin
    if (rstn) r2_v <= 1'b0;
    else      r2_v <= r1_v;
  end

  always_ff @(posedge clk) begin
    if (r1_v) begin
      r2_data <= red_sel;
      r2_tag  <= r1_tag;
    end
  end

`ifdef QPMM_OUT_RANGE_CHK_EN
  always_ff @(posedge clk) begin
    if (rstn)                 range_err <= 1'b0;
    else if (r1_v && r1_ge3)  range_err <= 1'b1;
  end
`endif

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      wr_nxt;
  logic [AW:0]      rd_nxt;
  logic [PW-1:0]    mem_data [DEPTH];
  logic [TAG_W-1:0] mem_tag  [DEPTH];
  logic             head_bypass;

  assign wr_nxt      = wr_ptr + (AW+1)'(r2_v);
  assign rd_nxt      = rd_ptr + (AW+1)'(pop);
  assign head_bypass = r2_v && (wr_ptr[AW-1:0] == rd_nxt[AW-1:0]);

  always_ff @(posedge clk) begin
    if (r2_v) begin
      mem_data[wr_ptr[AW-1:0]] <= r2_data;
      mem_tag[wr_ptr[AW-1:0]]  <= r2_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr      <= wr_nxt;
      rd_ptr      <= rd_nxt;
      out_valid_q <= (wr_nxt != rd_nxt);
    end
  end

  // Head register; a write can only land on the next head slot when the FIFO drains to empty.
  always_ff @(posedge clk) begin
    if (rstn) begin
      bus.out_data <= '0;
      bus.out_tag  <= '0;
    end else if (r2_v || pop) begin
      bus.out_data <= head_bypass ? r2_data : mem_data[rd_nxt[AW-1:0]];
      bus.out_tag  <= head_bypass ? r2_tag  : mem_tag[rd_nxt[AW-1:0]];
    end
  end

endmodule
